// File: rtl/bmi_input_collector_pkg.sv
// bmi_pkg: shared constants for the BMI input collector slice.
//   COLLECT/PRESENT - FSM state encoding
//   DATA_W          - reading / averaged output width
//   CNT_W           - width of the saturating reject/drop counters
//   NUM_KINDS       - reading kinds (index 0 = weight, 1 = height)
package bmi_pkg;

  localparam int DATA_W    = 8;
  localparam int CNT_W     = 8;
  localparam int NUM_KINDS = 2;
  localparam int KIND_H    = 1;

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;

  typedef struct packed {
    logic              is_height;
    logic [DATA_W-1:0] data;
  } sample_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bmi_input_collector_if.sv
// bmi_input_collector_if: sample stream in, classifier drive + stats out.
//   master - sample producer / consumer of results (testbench, upstream)
//   slave  - the collector
interface bmi_input_collector_if;

  logic                     sample_valid;
  logic                     sample_is_height;
  logic [bmi_pkg::DATA_W-1:0] sample_data;
  logic                     sample_ready;
  logic                     bmi_enable;
  logic [bmi_pkg::DATA_W-1:0] weight;
  logic [bmi_pkg::DATA_W-1:0] height;
  logic [bmi_pkg::CNT_W-1:0]  reject_count;
  logic [bmi_pkg::CNT_W-1:0]  drop_count;

  modport master (
    output sample_valid, sample_is_height, sample_data,
    input  sample_ready, bmi_enable, weight, height, reject_count, drop_count
  );

  modport slave (
    input  sample_valid, sample_is_height, sample_data,
    output sample_ready, bmi_enable, weight, height, reject_count, drop_count
  );

endinterface

// File: rtl/bmi_input_collector_accum.sv
// sample_accumulator: sums up to 2**SAMPLES_LOG2 readings of one kind.
//   clk, rst  - clock, async active-high reset
//   clear_i   - zero sum and count (takes priority over add_i)
//   add_i     - add data_i this edge (ignored once full)
//   data_i    - reading
//   full_o    - count has reached SAMPLES
//   avg_o     - sum >> SAMPLES_LOG2 (truncating mean)
module sample_accumulator
  import bmi_pkg::*;
#(
  parameter int SAMPLES_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              add_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full_o,
  output logic [DATA_W-1:0] avg_o
);

  // SAMPLES * 255 always fits in DATA_W + SAMPLES_LOG2 bits.
  localparam int ACC_W = DATA_W + SAMPLES_LOG2;
  localparam int CTR_W = SAMPLES_LOG2 + 1;
  localparam logic [CTR_W-1:0] SAMPLES = CTR_W'(1) << SAMPLES_LOG2;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CTR_W-1:0] cnt_q, cnt_d;

  assign full_o = (cnt_q == SAMPLES);
  assign avg_o  = DATA_W'(acc_q >> SAMPLES_LOG2);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (add_i && !full_o) begin
      acc_d = acc_q + ACC_W'(data_i);
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bmi_input_collector.sv
// bmi_input_collector: filters tagged weight/height readings, averages
// SAMPLES of each, then presents the averages with bmi_enable high for
// HOLD_CYCLES cycles before collecting the next set.
//   clk, rst - clock, async active-high reset
//   bus      - slave side of bmi_input_collector_if (samples in, results out)
module bmi_input_collector
  import bmi_pkg::*;
#(
  parameter int SAMPLES_LOG2 = 2,
  parameter int HOLD_CYCLES  = 8,
  parameter int MAX_HEIGHT   = 3
) (
  input logic                  clk,
  input logic                  rst,
  bmi_input_collector_if.slave bus
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [0:0]        state_q, state_d;
  logic              ready_q, ready_d;
  logic              en_q, en_d;
  logic [DATA_W-1:0] weight_q, weight_d;
  logic [DATA_W-1:0] height_q, height_d;
  logic [CNT_W-1:0]  rej_q, rej_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [NUM_KINDS-1:0]             full, add;
  logic [NUM_KINDS-1:0][DATA_W-1:0] avg;
  logic                             clear;

  logic xfer, is_rej, kind_full;

  // ready_q is only high in COLLECT, so xfer also implies COLLECT.
  assign xfer      = bus.sample_valid && ready_q;
  assign is_rej    = (bus.sample_data == '0) ||
                     (bus.sample_is_height && (bus.sample_data > DATA_W'(MAX_HEIGHT)));
  assign kind_full = full[bus.sample_is_height];
  assign clear     = (state_q == PRESENT) && (hold_q == '0);

  for (genvar k = 0; k < NUM_KINDS; k++) begin : g_kind
    assign add[k] = xfer && !is_rej && !kind_full &&
                    (bus.sample_is_height == (k == KIND_H));

    sample_accumulator #(.SAMPLES_LOG2(SAMPLES_LOG2)) u_acc (
      .clk    (clk),
      .rst    (rst),
      .clear_i(clear),
      .add_i  (add[k]),
      .data_i (bus.sample_data),
      .full_o (full[k]),
      .avg_o  (avg[k])
    );
  end

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    en_d     = en_q;
    weight_d = weight_q;
    height_d = height_q;
    rej_d    = rej_q;
    drop_d   = drop_q;
    hold_d   = hold_q;

    if (xfer) begin
      if (is_rej)         rej_d  = sat_inc(rej_q);
      else if (kind_full) drop_d = sat_inc(drop_q);
    end

    case (state_q)
      COLLECT: begin
        // Full flags are registered, so this fires one edge after the
        // final accept; a reading in that gap is counted as a drop.
        if (&full) begin
          state_d  = PRESENT;
          ready_d  = 1'b0;
          en_d     = 1'b1;
          weight_d = avg[0];
          height_d = avg[KIND_H];
          hold_d   = HOLD_W'(HOLD_CYCLES - 1);
        end
      end
      default: begin
        if (hold_q == '0) begin
          state_d = COLLECT;
          ready_d = 1'b1;
          en_d    = 1'b0;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= COLLECT;
      ready_q  <= 1'b1;
      en_q     <= 1'b0;
      weight_q <= '0;
      height_q <= '0;
      rej_q    <= '0;
      drop_q   <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      en_q     <= en_d;
      weight_q <= weight_d;
      height_q <= height_d;
      rej_q    <= rej_d;
      drop_q   <= drop_d;
      hold_q   <= hold_d;
    end
  end

  assign bus.sample_ready = ready_q;
  assign bus.bmi_enable   = en_q;
  assign bus.weight       = weight_q;
  assign bus.height       = height_q;
  assign bus.reject_count = rej_q;
  assign bus.drop_count   = drop_q;

endmodule
